// File: rtl/eth_pkt_slot_writer.sv
// eth_pkt_slot_writer: writes received Ethernet frames into a ring of fixed-size slots in packet RAM
// and queues one descriptor per complete frame. Optional frame counters: ETH_PKT_SLOT_WRITER_STATS_EN.
module eth_pkt_slot_writer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int SLOT_AW    = 11,
    parameter int NUM_SLOTS  = 4,
    parameter int SLOT_BITS  = 2,
    parameter int LEN_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic                  ram_oe,
    output logic                  pkt_valid,
    output logic [SLOT_BITS-1:0]  pkt_slot,
    output logic [ADDR_WIDTH-1:0] pkt_base_addr,
    output logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic                  pkt_ack,
    output logic                  drop_pulse
`ifdef ETH_PKT_SLOT_WRITER_STATS_EN
    ,
    output logic [31:0]           stat_rx_frames,
    output logic [31:0]           stat_drop_frames
`endif
);

    localparam int SLOT_SIZE = 1 << SLOT_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DROP,
        S_COMMIT
    } state_t;

    state_t                 state_reg, state_next;
    logic [LEN_WIDTH-1:0]   offset_reg, offset_next;
    logic [SLOT_BITS-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [SLOT_BITS:0]     occ_reg, occ_next;
    logic                   ready_reg;
    logic                   pkt_valid_reg;
    logic [ADDR_WIDTH-1:0]  ram_addr_reg;
    logic [DATA_WIDTH-1:0]  ram_data_reg;
    logic                   ram_we_reg;
    logic                   drop_reg;
    logic [LEN_WIDTH-1:0]   len_mem [NUM_SLOTS];

    logic                   accept;
    logic                   slots_full;
    logic                   commit;
    logic                   ack_take;
    logic                   wr_en;
    logic [SLOT_AW-1:0]     wr_off;
    logic                   drop;

    assign accept     = in_valid && ready_reg;
    assign slots_full = (occ_reg == (SLOT_BITS+1)'(NUM_SLOTS));
    assign commit     = (state_reg == S_COMMIT);
    assign ack_take   = pkt_ack && pkt_valid_reg;

    // Frame capture FSM: decides per accepted beat whether it is written, discarded or ends a frame.
    always_comb begin
        state_next  = state_reg;
        offset_next = offset_reg;
        wr_en       = 1'b0;
        wr_off      = offset_reg[SLOT_AW-1:0];
        drop        = 1'b0;
        case (state_reg)
            S_IDLE, S_DROP: begin
                if (accept && in_sop) begin
                    if (slots_full) begin
                        drop       = 1'b1;
                        state_next = in_eop ? S_IDLE : S_DROP;
                    end else begin
                        wr_en       = 1'b1;
                        wr_off      = '0;
                        offset_next = LEN_WIDTH'(1);
                        state_next  = in_eop ? S_COMMIT : S_WRITE;
                    end
                end else if (accept && in_eop && state_reg == S_DROP) begin
                    state_next = S_IDLE;
                end
            end
            S_WRITE: begin
                if (accept) begin
                    if (in_sop) begin
                        // A fresh sop reuses the slot being filled; the partial frame is simply overwritten.
                        wr_en       = 1'b1;
                        wr_off      = '0;
                        offset_next = LEN_WIDTH'(1);
                        state_next  = in_eop ? S_COMMIT : S_WRITE;
                    end else if (offset_reg == LEN_WIDTH'(SLOT_SIZE)) begin
                        drop       = 1'b1;
                        state_next = in_eop ? S_IDLE : S_DROP;
                    end else begin
                        wr_en       = 1'b1;
                        offset_next = offset_reg + 1'b1;
                        if (in_eop) begin
                            state_next = S_COMMIT;
                        end
                    end
                end
            end
            S_COMMIT: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        occ_next = occ_reg;
        if (commit && !ack_take) begin
            occ_next = occ_reg + 1'b1;
        end else if (!commit && ack_take) begin
            occ_next = occ_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            offset_reg    <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            occ_reg       <= '0;
            ready_reg     <= 1'b0;
            pkt_valid_reg <= 1'b0;
            drop_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            offset_reg    <= offset_next;
            occ_reg       <= occ_next;
            // COMMIT is the only state that refuses beats.
            ready_reg     <= (state_next != S_COMMIT);
            pkt_valid_reg <= (occ_next != '0);
            drop_reg      <= drop;
            if (commit) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (ack_take) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr_reg <= '0;
            ram_data_reg <= '0;
            ram_we_reg   <= 1'b0;
        end else begin
            ram_we_reg <= wr_en;
            if (wr_en) begin
                ram_addr_reg <= ADDR_WIDTH'({wr_ptr_reg, wr_off});
                ram_data_reg <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                len_mem[i] <= '0;
            end
        end else if (commit) begin
            len_mem[wr_ptr_reg] <= offset_reg;
        end
    end

`ifdef ETH_PKT_SLOT_WRITER_STATS_EN
    logic [31:0] stat_rx_reg;
    logic [31:0] stat_drop_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_rx_reg   <= '0;
            stat_drop_reg <= '0;
        end else begin
            if (commit && stat_rx_reg != '1) begin
                stat_rx_reg <= stat_rx_reg + 1'b1;
            end
            if (drop_reg && stat_drop_reg != '1) begin
                stat_drop_reg <= stat_drop_reg + 1'b1;
            end
        end
    end

    assign stat_rx_frames   = stat_rx_reg;
    assign stat_drop_frames = stat_drop_reg;
`endif

    assign in_ready      = ready_reg;
    assign ram_addr      = ram_addr_reg;
    assign ram_data      = ram_data_reg;
    assign ram_cs        = ram_we_reg;
    assign ram_we        = ram_we_reg;
    assign ram_oe        = 1'b0;
    assign pkt_valid     = pkt_valid_reg;
    assign pkt_slot      = rd_ptr_reg;
    assign pkt_base_addr = ADDR_WIDTH'({rd_ptr_reg, {SLOT_AW{1'b0}}});
    assign pkt_len       = len_mem[rd_ptr_reg];
    assign drop_pulse    = drop_reg;

endmodule
